serial_sub: RTL and testbench

Bit-serial N-bit subtractor computing A − B one bit per clock, LSB first, with a registered full-subtractor cell and a borrow flip-flop. It is the subtract-direction counterpart to the team's full-adder datapath cell. It sits beside the adder in the arithmetic datapath, trading area for latency. Operands are captured on a start handshake, and the difference, unsigned borrow and signed overflow are presented with a one-cycle done strobe.

---
 rtl/serial_sub.sv | 127 ++++++++++++
 tb/tb_serial_sub.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// Bit-serial N-bit subtractor: computes a - b one bit per clock, LSB first,
// reporting the difference, unsigned borrow and signed overflow with a done strobe.
module serial_sub #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] diff,
   output logic         borrow,
   output logic         ovf
);

   localparam int unsigned CW = (W > 2) ? $clog2(W) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t        state_q, state_d;

   logic [W-1:0]  sa_q, sb_q, res_q;
   logic [W-1:0]  res_d;
   logic [CW-1:0] cnt_q;
   logic          br_q, br_d;
   logic          a_sign_q, b_sign_q;
   logic          busy_q, done_q;
   logic [W-1:0]  diff_q;
   logic          borrow_q, ovf_q;

   logic          accept_c, step_c, last_c;
   logic          ai_c, bi_c, d_c;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // FSM next-state: leave IDLE on accept, return after the top bit is processed
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (cnt_q == LAST_BIT) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM output decode: datapath control strobes
   always_comb begin
      accept_c = 1'b0;
      step_c   = 1'b0;
      last_c   = 1'b0;
      case (state_q)
         IDLE: accept_c = start;
         RUN: begin
            step_c = 1'b1;
            last_c = (cnt_q == LAST_BIT);
         end
         default: ;
      endcase
   end

   // Full-subtractor cell on the current operand LSBs
   always_comb begin
      ai_c  = sa_q[0];
      bi_c  = sb_q[0];
      d_c   = ai_c ^ bi_c ^ br_q;
      br_d  = (~ai_c & bi_c) | (~(ai_c ^ bi_c) & br_q);
      res_d = {d_c, res_q[W-1:1]};
   end

   // Operand/result shift registers, borrow flop, counter and held outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         sa_q     <= '0;
         sb_q     <= '0;
         res_q    <= '0;
         cnt_q    <= '0;
         br_q     <= 1'b0;
         a_sign_q <= 1'b0;
         b_sign_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         done_q <= last_c;
         if (accept_c) begin
            sa_q     <= a;
            sb_q     <= b;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            a_sign_q <= a[W-1];
            b_sign_q <= b[W-1];
            busy_q   <= 1'b1;
         end else if (step_c) begin
            sa_q  <= sa_q >> 1;
            sb_q  <= sb_q >> 1;
            res_q <= res_d;
            br_q  <= br_d;
            cnt_q <= cnt_q + CW'(1);
            if (last_c) begin
               diff_q   <= res_d;
               borrow_q <= br_d;
               ovf_q    <= (a_sign_q != b_sign_q) & (d_c != a_sign_q);
               busy_q   <= 1'b0;
            end
         end
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign diff   = diff_q;
   assign borrow = borrow_q;
   assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: stimulus queues expected results from an
// arithmetic reference model, a monitor pops and compares on each done pulse.
module tb_serial_sub;

   localparam int unsigned W = 8;

   typedef struct {
      logic [W-1:0] diff;
      logic         borrow;
      logic         ovf;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a, b;
   logic         busy, done;
   logic [W-1:0] diff;
   logic         borrow, ovf;

   int checks   = 0;
   int failures = 0;

   exp_t sb_q[$];

   serial_sub #(.W(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .borrow (borrow),
      .ovf    (ovf)
   );

   always #5 clk = ~clk;

   // Compare helper
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: plain integer arithmetic on unsigned and signed views
   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t r;
      int   ux, uy, sx, sy, rs;
      ux = int'(x);
      uy = int'(y);
      sx = x[W-1] ? ux - (2 ** W) : ux;
      sy = y[W-1] ? uy - (2 ** W) : uy;
      rs = sx - sy;
      r.diff   = W'(ux - uy);
      r.borrow = (ux < uy);
      r.ovf    = (rs < -(2 ** (W - 1))) || (rs > (2 ** (W - 1)) - 1);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) until the DUT is not busy
   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin
         tick();
         n++;
      end
      if (busy) chk("wait_idle_timeout", 1, 0);
   endtask

   // Issue one accepted operation; optionally record its expected result
   task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
      wait_idle();
      start = 1'b1;
      a     = x;
      b     = y;
      if (push) sb_q.push_back(model(x, y));
      tick();
      start = 1'b0;
   endtask

   // Monitor: result checks on done, done width and busy width
   initial begin : monitor
      int   bcnt = 0;
      logic prev_done = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (done) begin
            chk("done_one_cycle", int'(prev_done), 0);
            if (sb_q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = sb_q.pop_front();
               chk("diff", int'(diff), int'(e.diff));
               chk("borrow", int'(borrow), int'(e.borrow));
               chk("ovf", int'(ovf), int'(e.ovf));
            end
         end
         prev_done = done;
         if (rst) bcnt = 0;
         else if (busy) bcnt++;
         else if (bcnt != 0) begin
            chk("busy_cycles", bcnt, int'(W));
            bcnt = 0;
         end
      end
   end

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (3) tick();
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_diff", int'(diff), 0);
      chk("rst_borrow", int'(borrow), 0);
      chk("rst_ovf", int'(ovf), 0);
      rst = 1'b0;
      tick();

      // Directed cases
      do_op(8'd200, 8'd55, 1'b1);
      do_op(8'd5,   8'd10, 1'b1);
      do_op(8'h80,  8'h01, 1'b1);
      do_op(8'h7F,  8'hFF, 1'b1);
      do_op(8'd0,   8'd0,  1'b1);
      wait_idle();
      repeat (3) tick();

      // start while busy is ignored
      do_op(8'd9, 8'd3, 1'b1);
      tick();
      tick();
      start = 1'b1;
      a     = 8'd1;
      b     = 8'd2;
      tick();
      start = 1'b0;
      wait_idle();
      repeat (12) tick();
      chk("ignored_no_extra", sb_q.size(), 0);

      // Back-to-back with start held high
      start = 1'b1;
      a     = 8'd9;
      b     = 8'd3;
      sb_q.push_back(model(8'd9, 8'd3));
      tick();
      repeat (W - 1) tick();
      tick();
      chk("b2b_done_cycle_busy", int'(busy), 0);
      a = 8'd1;
      b = 8'd2;
      sb_q.push_back(model(8'd1, 8'd2));
      tick();
      chk("b2b_second_accept", int'(busy), 1);
      start = 1'b0;
      wait_idle();
      repeat (3) tick();

      // Reset mid-operation
      do_op(8'd77, 8'd12, 1'b0);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_diff", int'(diff), 0);
      chk("abort_borrow", int'(borrow), 0);
      chk("abort_ovf", int'(ovf), 0);
      repeat (12) tick();
      do_op(8'd100, 8'd1, 1'b1);

      // Randomised operations with random gaps
      for (int i = 0; i < 40; i++) begin
         do_op(W'($urandom), W'($urandom), 1'b1);
         repeat ($urandom_range(0, 2)) tick();
      end

      wait_idle();
      repeat (5) tick();
      chk("scoreboard_empty", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
